// File: rtl/range_finder_wd_pkg.sv
// Shared types and constants for the watchdog-kick arbiter and its timers.
package range_finder_wd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SW_XFER = 2'd1,
    HB_XFER = 2'd2
  } state_e;

  typedef enum logic {
    GRANT_SW = 1'b0,
    GRANT_HB = 1'b1
  } grant_e;

  localparam logic [1:0] PIO_KICK_ADDR = 2'd0;

endpackage

// File: rtl/range_finder_wd_timer.sv
// Enabled up-counter that either wraps at LIMIT-1 or saturates at LIMIT;
// tc_o pulses on the enabled cycle in which the count sits at LIMIT-1.
module range_finder_wd_timer #(
  parameter int unsigned LIMIT = 8,
  parameter int          CNT_W = 32,
  parameter bit          WRAP  = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic clr_i,
  output logic tc_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);
  localparam logic [CNT_W-1:0] SAT  = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tc_o = en_i & ~clr_i & (cnt_q == LAST);

  always_comb begin
    // NOTE: defaulting every always_comb output first keeps paths that assign nothing from inferring a latch.
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (WRAP && (cnt_q == LAST)) begin
        cnt_d = '0;
      end else if (WRAP || (cnt_q != SAT)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/range_finder_wd_kick_arbiter.sv
// Shares the watchdog-kick PIO between the CPU and a hardware heartbeat,
// and raises a sticky fault when no address-0 write lands within TIMEOUT.
module range_finder_wd_kick_arbiter
  import range_finder_wd_pkg::*;
#(
  parameter int unsigned HB_PERIOD = 50000000,
  parameter int unsigned TIMEOUT   = 100000000,
  parameter int          CNT_W     = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hb_enable,
  input  logic        fault_clear,
  input  logic        sw_chipselect,
  input  logic        sw_read_n,
  input  logic        sw_write_n,
  input  logic [1:0]  sw_address,
  input  logic [31:0] sw_writedata,
  output logic [31:0] sw_readdata,
  output logic        sw_waitrequest,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [1:0]  m_address,
  output logic [31:0] m_writedata,
  input  logic [31:0] m_readdata,
  output logic        wd_fault
);

  state_e state_q, state_d;
  grant_e last_grant_q, last_grant_d;
  logic   hb_level_q, hb_level_d;
  logic   hb_pending_q, hb_pending_d;
  logic   wd_fault_q, wd_fault_d;
  logic   sw_req, sw_kick, kick_wr, hb_tc, to_tc;

  assign sw_req  = sw_chipselect & (~sw_read_n | ~sw_write_n);
  assign sw_kick = (state_q == SW_XFER) & ~sw_write_n & (sw_address == PIO_KICK_ADDR);
  assign kick_wr = sw_kick | (state_q == HB_XFER);

  // Master outputs are decoded from state so an abort by reset idles the bus at once.
  always_comb begin
    state_d        = state_q;
    m_chipselect   = 1'b0;
    m_write_n      = 1'b1;
    m_address      = '0;
    m_writedata    = '0;
    sw_waitrequest = 1'b1;
    sw_readdata    = '0;
    unique case (state_q)
      IDLE: begin
        if (sw_req && hb_pending_q) begin
          state_d = (last_grant_q == GRANT_HB) ? SW_XFER : HB_XFER;
        end else if (sw_req) begin
          state_d = SW_XFER;
        end else if (hb_pending_q) begin
          state_d = HB_XFER;
        end
      end
      SW_XFER: begin
        m_chipselect   = 1'b1;
        m_write_n      = sw_write_n;
        m_address      = sw_address;
        m_writedata    = sw_writedata;
        sw_waitrequest = 1'b0;
        sw_readdata    = m_readdata;
        state_d        = IDLE;
      end
      HB_XFER: begin
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        m_address    = PIO_KICK_ADDR;
        m_writedata  = {31'b0, ~hb_level_q};
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    last_grant_d = last_grant_q;
    hb_level_d   = hb_level_q;
    hb_pending_d = hb_pending_q;
    wd_fault_d   = wd_fault_q;
    if (state_q == SW_XFER) begin
      last_grant_d = GRANT_SW;
    end
    // The CPU may overwrite the kick bit; track it so the next heartbeat really toggles.
    if (sw_kick) begin
      hb_level_d = sw_writedata[0];
    end
    if (state_q == HB_XFER) begin
      last_grant_d = GRANT_HB;
      hb_level_d   = ~hb_level_q;
    end
    if ((state_q == HB_XFER) || !hb_enable) begin
      hb_pending_d = 1'b0;
    end else if (hb_tc) begin
      hb_pending_d = 1'b1;
    end
    if (fault_clear) begin
      wd_fault_d = 1'b0;
    end else if (to_tc) begin
      wd_fault_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_HB;
      hb_level_q   <= 1'b0;
      hb_pending_q <= 1'b0;
      wd_fault_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      hb_level_q   <= hb_level_d;
      hb_pending_q <= hb_pending_d;
      wd_fault_q   <= wd_fault_d;
    end
  end

  assign wd_fault = wd_fault_q;

  range_finder_wd_timer #(
    .LIMIT (HB_PERIOD),
    .CNT_W (CNT_W),
    .WRAP  (1'b1)
  ) u_hb_timer (
    .clk   (clk),
    .reset (reset),
    .en_i  (hb_enable),
    .clr_i (~hb_enable),
    .tc_o  (hb_tc)
  );

  range_finder_wd_timer #(
    .LIMIT (TIMEOUT),
    .CNT_W (CNT_W),
    .WRAP  (1'b0)
  ) u_to_timer (
    .clk   (clk),
    .reset (reset),
    .en_i  (1'b1),
    .clr_i (kick_wr | fault_clear),
    .tc_o  (to_tc)
  );

endmodule

// File: tb/tb_range_finder_wd_kick_arbiter.sv
// Directed bench for the watchdog-kick arbiter: a CPU transaction table plus
// hand-timed sequences for heartbeat, arbitration, timeout and reset abort.
module tb_range_finder_wd_kick_arbiter;

  localparam int unsigned HB_P = 8;
  localparam int unsigned TO   = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        hb_enable = 1'b0;
  logic        fault_clear = 1'b0;
  logic        sw_chipselect = 1'b0;
  logic        sw_read_n = 1'b1;
  logic        sw_write_n = 1'b1;
  logic [1:0]  sw_address = 2'd0;
  logic [31:0] sw_writedata = 32'd0;
  logic [31:0] sw_readdata;
  logic        sw_waitrequest;
  logic        m_chipselect;
  logic        m_write_n;
  logic [1:0]  m_address;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata;
  logic        wd_fault;

  always #5 clk = ~clk;

  range_finder_wd_kick_arbiter #(
    .HB_PERIOD (HB_P),
    .TIMEOUT   (TO),
    .CNT_W     (32)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .hb_enable      (hb_enable),
    .fault_clear    (fault_clear),
    .sw_chipselect  (sw_chipselect),
    .sw_read_n      (sw_read_n),
    .sw_write_n     (sw_write_n),
    .sw_address     (sw_address),
    .sw_writedata   (sw_writedata),
    .sw_readdata    (sw_readdata),
    .sw_waitrequest (sw_waitrequest),
    .m_chipselect   (m_chipselect),
    .m_write_n      (m_write_n),
    .m_address      (m_address),
    .m_writedata    (m_writedata),
    .m_readdata     (m_readdata),
    .wd_fault       (wd_fault)
  );

  // PIO model: kick bit at address 0, fixed patterns elsewhere.
  logic        pio_q = 1'b0;
  int          cyc = 0;
  logic [31:0] kick_data[$];
  int          kick_cyc[$];

  assign m_readdata = (m_address == 2'd0) ? {31'd0, pio_q} : {16'hA5A5, 14'd0, m_address};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (m_chipselect && !m_write_n && (m_address == 2'd0)) begin
      pio_q <= m_writedata[0];
      kick_data.push_back(m_writedata);
      kick_cyc.push_back(cyc + 1);
    end
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_neg(input int t);
    do @(negedge clk); while (cyc < t);
  endtask

  task automatic do_reset(input logic hb_after, output int rel);
    @(posedge clk); #1;
    reset = 1'b1; hb_enable = 1'b0; fault_clear = 1'b0;
    sw_chipselect = 1'b0; sw_read_n = 1'b1; sw_write_n = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0; hb_enable = hb_after;
    rel = cyc;
  endtask

  // Issues a request and returns at the negedge where waitrequest is low (or the bound expires).
  task automatic cpu_xfer(input logic wr, input logic [1:0] addr, input logic [31:0] wdata,
                          output int lat);
    @(posedge clk); #1;
    sw_chipselect = 1'b1; sw_read_n = wr; sw_write_n = ~wr;
    sw_address = addr; sw_writedata = wdata;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (sw_waitrequest !== 1'b0 && lat < 8);
  endtask

  task automatic cpu_release();
    @(posedge clk); #1;
    sw_chipselect = 1'b0; sw_read_n = 1'b1; sw_write_n = 1'b1;
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        chk_rd;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int   rel, lat, kb, c0, n;
    logic exp_wn, fault_seen, got;

    vecs[0] = '{1'b1, 2'd0, 32'hFFFF_FFFE, 32'h0000_0000, 1'b0};
    vecs[1] = '{1'b0, 2'd0, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[2] = '{1'b1, 2'd2, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vecs[3] = '{1'b0, 2'd3, 32'h0000_0000, 32'hA5A5_0003, 1'b1};
    vecs[4] = '{1'b0, 2'd1, 32'h1234_5678, 32'hA5A5_0001, 1'b1};
    vecs[5] = '{1'b1, 2'd0, 32'h0000_0001, 32'h0000_0000, 1'b0};
    vecs[6] = '{1'b0, 2'd0, 32'h0000_0000, 32'h0000_0001, 1'b1};
    vecs[7] = '{1'b1, 2'd3, 32'h0000_0000, 32'h0000_0000, 1'b0};

    // Reset values, then the timeout fault with no traffic at all.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_m_chipselect", m_chipselect, 0);
    check("rst_m_write_n", m_write_n, 1);
    check("rst_m_address", m_address, 0);
    check("rst_m_writedata", m_writedata, 0);
    check("rst_sw_waitrequest", sw_waitrequest, 1);
    check("rst_sw_readdata", sw_readdata, 0);
    check("rst_wd_fault", wd_fault, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    rel = cyc;
    wait_neg(rel + 19);
    check("idle_fault_at_19", wd_fault, 0);
    check("idle_no_master_cs", m_chipselect, 0);
    wait_neg(rel + 20);
    check("idle_fault_at_20", wd_fault, 1);

    // fault_clear drops the fault next cycle and restarts the timeout.
    @(posedge clk); #1;
    fault_clear = 1'b1;
    @(posedge clk); #1;
    fault_clear = 1'b0;
    c0 = cyc;
    @(negedge clk);
    check("fault_clear_next", wd_fault, 0);
    wait_neg(c0 + 19);
    check("refault_at_19", wd_fault, 0);
    wait_neg(c0 + 20);
    check("refault_at_20", wd_fault, 1);

    // Traffic to addresses 1-3 and reads of 0 never clear the timeout.
    do_reset(1'b0, rel);
    cpu_xfer(1'b1, 2'd1, 32'h1, lat); check("pt_w1_lat", lat, 2); cpu_release();
    cpu_xfer(1'b1, 2'd2, 32'h2, lat); check("pt_w2_lat", lat, 2); cpu_release();
    cpu_xfer(1'b1, 2'd3, 32'h3, lat); check("pt_w3_lat", lat, 2); cpu_release();
    cpu_xfer(1'b0, 2'd0, 32'h0, lat); check("pt_r0_lat", lat, 2); cpu_release();
    wait_neg(rel + 19);
    check("pt_fault_at_19", wd_fault, 0);
    wait_neg(rel + 20);
    check("pt_fault_at_20", wd_fault, 1);

    // CPU transaction table, heartbeat off.
    do_reset(1'b0, rel);
    for (int i = 0; i < 8; i++) begin
      cpu_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, lat);
      exp_wn = ~vecs[i].wr;
      check($sformatf("vec%0d_latency", i), lat, 2);
      check($sformatf("vec%0d_m_chipselect", i), m_chipselect, 1);
      check($sformatf("vec%0d_m_write_n", i), m_write_n, exp_wn);
      check($sformatf("vec%0d_m_address", i), m_address, vecs[i].addr);
      check($sformatf("vec%0d_m_writedata", i), m_writedata, vecs[i].wdata);
      if (vecs[i].chk_rd) begin
        check($sformatf("vec%0d_sw_readdata", i), sw_readdata, vecs[i].exp_rdata);
      end
      cpu_release();
    end

    // The CPU left the kick bit at 1, so the next heartbeat must write 0.
    kb = kick_data.size();
    hb_enable = 1'b1;
    n = 0;
    while (kick_data.size() == kb && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("shadow_hb_seen", (kick_data.size() > kb), 1);
    if (kick_data.size() > kb) check("shadow_hb_data", kick_data[kb], 32'h0);

    // Free-running heartbeat: period, alternating data, no fault.
    do_reset(1'b1, rel);
    kb = kick_data.size();
    fault_seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (wd_fault !== 1'b0) fault_seen = 1'b1;
    end
    check("hb_no_fault_200", fault_seen, 0);
    check("hb_kick_count", kick_data.size() - kb, 24);
    if (kick_data.size() >= kb + 4) begin
      check("hb_first_kick_cycle", kick_cyc[kb] - rel, 10);
      for (int i = 0; i < 4; i++) begin
        check($sformatf("hb_data%0d", i), kick_data[kb + i], (i % 2 == 0) ? 32'h1 : 32'h0);
        if (i > 0) check($sformatf("hb_period%0d", i), kick_cyc[kb + i] - kick_cyc[kb + i - 1], HB_P);
      end
    end

    // Arbitration: last_grant=HB after reset, so SW wins the first tie.
    do_reset(1'b1, rel);
    wait_neg(rel + 7);
    @(posedge clk); #1;
    sw_chipselect = 1'b1; sw_read_n = 1'b0; sw_write_n = 1'b1; sw_address = 2'd1;
    wait_neg(rel + 9);
    check("arb1_sw_first_wait", sw_waitrequest, 0);
    check("arb1_sw_first_rd", sw_readdata, 32'hA5A5_0001);
    cpu_release();
    wait_neg(rel + 11);
    check("arb1_hb_next_cs", m_chipselect, 1);
    check("arb1_hb_next_wn", m_write_n, 0);
    check("arb1_hb_next_data", m_writedata, 32'h1);
    cpu_xfer(1'b0, 2'd2, 32'h0, lat);
    check("arb_mid_lat", lat, 2);
    check("arb_mid_rd", sw_readdata, 32'hA5A5_0002);
    cpu_release();
    // last_grant=SW now: the next tie goes to the heartbeat.
    wait_neg(rel + 15);
    @(posedge clk); #1;
    sw_chipselect = 1'b1; sw_read_n = 1'b0; sw_write_n = 1'b1; sw_address = 2'd3;
    wait_neg(rel + 17);
    check("arb2_hb_first_cs", m_chipselect, 1);
    check("arb2_hb_first_wn", m_write_n, 0);
    check("arb2_hb_first_data", m_writedata, 32'h0);
    check("arb2_hb_first_wait", sw_waitrequest, 1);
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      @(negedge clk);
      if (sw_waitrequest === 1'b0) begin
        got = 1'b1;
        check("arb2_sw_next_rd", sw_readdata, 32'hA5A5_0003);
      end
    end
    check("arb2_sw_served", got, 1);
    cpu_release();

    // Reset during SW_XFER: master idles next cycle and the write is not reissued.
    do_reset(1'b0, rel);
    kb = kick_data.size();
    cpu_xfer(1'b1, 2'd0, 32'h1, lat);
    check("rstx_lat", lat, 2);
    reset = 1'b1;
    @(negedge clk);
    check("rstx_m_cs_idle", m_chipselect, 0);
    check("rstx_wait_high", sw_waitrequest, 1);
    @(negedge clk);
    check("rstx_m_wn_idle", m_write_n, 1);
    @(posedge clk); #1;
    sw_chipselect = 1'b0; sw_read_n = 1'b1; sw_write_n = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("rstx_single_write", kick_data.size() - kb, 1);
    if (kick_data.size() > kb) check("rstx_write_data", kick_data[kb], 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
